bmc_rx_sampler: RTL

Front-end of the optical receive path. It takes the raw comparator output from the photodiode, oversampled at `clk`, and recovers half-bit timing from the Biphase Mark transitions. It emits one mid-half-bit sample per `o_valid` strobe, aligned so the first strobe after lock is the first half of a bit. Its `o_halfbit`/`o_valid` pair drives the BMC decoder's serial input and valid strobe directly.

---
 rtl/bmc_pkg.sv | 8 +
 rtl/bmc_rx_sampler_if.sv | 11 +
 rtl/bmc_rx_sync.sv | 21 ++
 rtl/bmc_rx_sampler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/bmc_pkg.sv
// bmc_pkg: shared state/edge-class types and gap-counter sizing for the BMC receive path
package bmc_pkg;
  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_e;
  typedef enum logic [1:0] {SHORT, LONG, BAD} eclass_e;
  function automatic int gap_width(input int half_period, input int tol);
    return $clog2(2 * half_period + tol + 2);
  endfunction
endpackage

// File: rtl/bmc_rx_sampler_if.sv
// bmc_rx_sampler_if: raw optical input and recovered half-bit sample stream
interface bmc_rx_sampler_if;
  logic rx_in;
  logic o_halfbit;
  logic o_valid;
  logic o_first;
  logic o_locked;
  logic o_err;
  modport master (input rx_in, output o_halfbit, o_valid, o_first, o_locked, o_err);
  modport slave (output rx_in, input o_halfbit, o_valid, o_first, o_locked, o_err);
endinterface

// File: rtl/bmc_rx_sync.sv
// bmc_rx_sync: 2-flop synchronizer; BMC_RX_GLITCH_FILTER_EN adds a 3-sample majority filter
module bmc_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic rx_clean_o
);
  logic s1_q, s2_q;
  // two-stage synchronizer for the asynchronous comparator output
  always_ff @(posedge clk)
    {s2_q, s1_q} <= rst ? 2'b00 : {s1_q, rx_i};
`ifdef BMC_RX_GLITCH_FILTER_EN
  logic h1_q, h2_q;
  // history of the synchronized signal; a lone glitch never wins the 2-of-3 vote
  always_ff @(posedge clk)
    {h2_q, h1_q} <= rst ? 2'b00 : {h1_q, s2_q};
  assign rx_clean_o = (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
`else
  assign rx_clean_o = s2_q;
`endif
endmodule

// File: rtl/bmc_rx_sampler.sv
// bmc_rx_sampler: recovers BMC half-bit timing and emits one mid-half-bit sample per strobe
module bmc_rx_sampler
  import bmc_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int TOL         = 2,
  parameter int LOCK_EDGES  = 16
) (
  input  logic              clk,
  input  logic              rst,
  bmc_rx_sampler_if.master  bus
);
  localparam int GW = gap_width(HALF_PERIOD, TOL);
  localparam int PW = $clog2(HALF_PERIOD);
  localparam int CW = $clog2(LOCK_EDGES + 1);
  localparam logic [GW-1:0] SAT_V = GW'(2 * HALF_PERIOD + TOL + 1);
  localparam logic [GW-1:0] S_LO  = GW'(HALF_PERIOD - TOL);
  localparam logic [GW-1:0] S_HI  = GW'(HALF_PERIOD + TOL);
  localparam logic [GW-1:0] L_LO  = GW'(2 * HALF_PERIOD - TOL);
  localparam logic [GW-1:0] L_HI  = GW'(2 * HALF_PERIOD + TOL);
  localparam logic [PW-1:0] PH_MID  = PW'(HALF_PERIOD / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_EDGES);
  localparam logic [1:0] S_HUNT = HUNT;
  localparam logic [1:0] S_ACQ  = ACQUIRE;
  localparam logic [1:0] S_LOCK = LOCKED;

  logic          rx_clean, rx_edge, sample;
  logic          prev_q;
  logic [GW-1:0] gap_q;
  logic [PW-1:0] ph_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hb_q, hb_d;
  logic          halfbit_q, halfbit_d, valid_q, valid_d, first_q, first_d;
  logic          locked_q, err_q, err_d;
  eclass_e       cls;

  bmc_rx_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (bus.rx_in),
    .rx_clean_o (rx_clean)
  );

  assign rx_edge = rx_clean ^ prev_q;
  assign sample  = (ph_q == PH_MID) && !rx_edge;

  // classify each edge by the spacing since the previous one
  always_comb
    cls = (gap_q >= S_LO && gap_q <= S_HI) ? SHORT :
          (gap_q >= L_LO && gap_q <= L_HI) ? LONG : BAD;

  // edge history, saturating gap counter and half-bit phase counter
  always_ff @(posedge clk)
    if (rst) begin
      prev_q <= 1'b0;
      gap_q  <= '0;
      ph_q   <= '0;
    end else begin
      prev_q <= rx_clean;
      gap_q  <= rx_edge ? GW'(1) : (gap_q == SAT_V) ? gap_q : gap_q + 1'b1;
      ph_q   <= (rx_edge || ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end

  // hunt/acquire/lock sequencing and sample emission; an edge always beats a sample
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hb_d      = hb_q;
    halfbit_d = halfbit_q;
    valid_d   = 1'b0;
    first_d   = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_HUNT) begin
      if (rx_edge && cls != BAD) begin
        state_d = S_ACQ;
        cnt_d   = CW'(1);
      end
    end else if (state_q == S_ACQ) begin
      if (rx_edge && cls == BAD)
        state_d = S_HUNT;
      else if (rx_edge) begin
        cnt_d = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q >= CNT_MAX && cls == LONG) begin
          state_d = S_LOCK;
          hb_d    = 1'b0;
        end
      end
    end else if (state_q == S_LOCK) begin
      if (rx_edge ? (cls == BAD || (cls == LONG && hb_q)) : (gap_q == SAT_V)) begin
        state_d = S_HUNT;
        err_d   = 1'b1;
      end else if (sample) begin
        valid_d   = 1'b1;
        halfbit_d = rx_clean;
        first_d   = !hb_q;
        hb_d      = !hb_q;
      end
    end
  end

  // state and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      state_q   <= S_HUNT;
      cnt_q     <= '0;
      hb_q      <= 1'b0;
      halfbit_q <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hb_q      <= hb_d;
      halfbit_q <= halfbit_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      locked_q  <= (state_d == S_LOCK);
      err_q     <= err_d;
    end

  assign bus.o_halfbit = halfbit_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_first   = first_q;
  assign bus.o_locked  = locked_q;
  assign bus.o_err     = err_q;
endmodule
